// File: rtl/mct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mct_pkg
//  Description : Shared types and constants for the MCT read scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mct_pkg;

    localparam int CL_BYTES_LOG2 = 6;

    localparam logic STYPE_NFA   = 1'b0;
    localparam logic STYPE_QUERY = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NFA_AR  = 3'd1,
        BARRIER = 3'd2,
        QRY_AR  = 3'd3,
        DRAIN   = 3'd4
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/mct_rd_beat_tagger.sv
`default_nettype none
// ============================================================================
//  Module      : mct_rd_beat_tagger
//  Description : Counts accepted R beats and derives stream type and tlast.
//  Revision    : 1.0 - initial release
// ============================================================================
module mct_rd_beat_tagger
    import mct_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        beat_fire_i,
    input  logic [31:0] nfa_len_i,
    input  logic [32:0] total_len_i,
    output logic        ttype_o,
    output logic        tlast_o,
    output logic        nfa_complete_o,
    output logic        final_beat_o
);

    logic [32:0] cnt_q, cnt_d;
    logic [32:0] w_nfa_len;
    logic        w_at_nfa_last;
    logic        w_at_total_last;

    assign w_nfa_len = {1'b0, nfa_len_i};

    // Zero-length guards keep the wrapped "len-1" from ever matching.
    assign w_at_nfa_last   = (nfa_len_i != 32'd0) && (cnt_q == w_nfa_len - 33'd1);
    assign w_at_total_last = (total_len_i != 33'd0) && (cnt_q == total_len_i - 33'd1);

    assign ttype_o        = (cnt_q >= w_nfa_len) ? STYPE_QUERY : STYPE_NFA;
    assign tlast_o        = w_at_nfa_last | w_at_total_last;
    assign nfa_complete_o = (cnt_q >= w_nfa_len) | (beat_fire_i & w_at_nfa_last);
    assign final_beat_o   = beat_fire_i & w_at_total_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 33'd0;
        end else if (beat_fire_i) begin
            cnt_d = cnt_q + 33'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 33'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mct_rd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mct_rd_scheduler
//  Description : Sequences NFA then query reads onto one AXI AR channel and
//                tags returned beats. MCT_RD_PHASE_BARRIER_EN holds the first
//                query AR until every NFA beat has been accepted downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module mct_rd_scheduler
    import mct_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start,
    output logic                    ctrl_done,
    input  logic [C_ADDR_WIDTH-1:0] nfa_addr,
    input  logic [31:0]             nfa_numcls,
    input  logic [C_ADDR_WIDTH-1:0] query_addr,
    input  logic [31:0]             query_numcls,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                    m_axi_rlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_ttype,
    output logic                    m_axis_tlast
);

    localparam int              OUT_W   = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [31:0]      BURST   = 32'(C_BURST_LEN);

    rd_state_t               state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_ADDR_WIDTH-1:0] qry_addr_q, qry_addr_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]             rem_q, rem_d;
    logic [31:0]             qry_rem_q, qry_rem_d;
    logic [31:0]             nfa_len_q, nfa_len_d;
    logic [32:0]             total_q, total_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    done_q, done_d;
    logic [OUT_W-1:0]        out_q, out_d;

    logic        w_busy, w_start, w_ar_fire, w_ar_last, w_beat_fire, w_rlast_fire;
    logic [31:0] w_beats_q, w_beats_d;
    logic        w_nfa_complete, w_final_beat;

    function automatic logic [31:0] burst_beats(input logic [31:0] rem);
        return (rem < BURST) ? rem : BURST;
    endfunction

    assign w_busy        = (state_q != IDLE);
    assign w_start       = (state_q == IDLE) & ctrl_start;
    assign m_axi_rready  = w_busy & m_axis_tready;
    assign m_axis_tvalid = w_busy & m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign w_beat_fire   = m_axis_tvalid & m_axis_tready;
    assign w_rlast_fire  = w_beat_fire & m_axi_rlast;
    assign w_ar_fire     = arvalid_q & m_axi_arready;
    assign w_beats_q     = burst_beats(rem_q);
    assign w_ar_last     = w_ar_fire & (rem_q == w_beats_q);

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign ctrl_done     = done_q;

    mct_rd_beat_tagger u_tagger (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (w_start),
        .beat_fire_i    (w_beat_fire),
        .nfa_len_i      (nfa_len_q),
        .total_len_i    (total_q),
        .ttype_o        (m_axis_ttype),
        .tlast_o        (m_axis_tlast),
        .nfa_complete_o (w_nfa_complete),
        .final_beat_o   (w_final_beat)
    );

`ifndef MCT_RD_PHASE_BARRIER_EN
    logic w_unused_nfa_complete;
    assign w_unused_nfa_complete = w_nfa_complete;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        qry_addr_d = qry_addr_q;
        qry_rem_d  = qry_rem_q;
        nfa_len_d  = nfa_len_q;
        total_d    = total_q;
        done_d     = 1'b0;

        if (w_ar_fire) begin
            addr_d = addr_q + (C_ADDR_WIDTH'(w_beats_q) << CL_BYTES_LOG2);
            rem_d  = rem_q - w_beats_q;
        end

        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    nfa_len_d  = nfa_numcls;
                    qry_addr_d = query_addr;
                    qry_rem_d  = query_numcls;
                    total_d    = {1'b0, nfa_numcls} + {1'b0, query_numcls};
                    if (nfa_numcls != 32'd0) begin
                        state_d = NFA_AR;
                        addr_d  = nfa_addr;
                        rem_d   = nfa_numcls;
                    end else if (query_numcls != 32'd0) begin
                        state_d = QRY_AR;
                        addr_d  = query_addr;
                        rem_d   = query_numcls;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            NFA_AR: begin
                if (w_ar_last) begin
                    if (qry_rem_q == 32'd0) begin
                        state_d = DRAIN;
                    end else begin
`ifdef MCT_RD_PHASE_BARRIER_EN
                        state_d = BARRIER;
`else
                        state_d = QRY_AR;
`endif
                        addr_d = qry_addr_q;
                        rem_d  = qry_rem_q;
                    end
                end
            end
            BARRIER: begin
                if (w_nfa_complete) begin
                    state_d = QRY_AR;
                end
            end
            QRY_AR: begin
                if (w_ar_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case ({w_ar_fire, w_rlast_fire && (out_q != '0)})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        // Next AR is staged from next-state values so bursts can go back-to-back.
        w_beats_d = burst_beats(rem_d);
        arvalid_d = 1'b0;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        if (arvalid_q && !m_axi_arready) begin
            arvalid_d = 1'b1;
        end else if ((state_d == NFA_AR || state_d == QRY_AR) &&
                     (rem_d != 32'd0) && (out_d < MAX_OUT)) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_d;
            arlen_d   = 8'(w_beats_d - 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            qry_addr_q <= '0;
            qry_rem_q  <= '0;
            nfa_len_q  <= '0;
            total_q    <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            qry_addr_q <= qry_addr_d;
            qry_rem_q  <= qry_rem_d;
            nfa_len_q  <= nfa_len_d;
            total_q    <= total_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
            done_q     <= done_d;
            out_q      <= out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mct_rd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mct_rd_scheduler
//  Description : Scoreboard bench for mct_rd_scheduler with an AXI read model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mct_rd_scheduler;

    localparam int MAXO = 2;
    localparam int BIG  = 1000000;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [511:0] data;
        logic         ttype;
        logic         tlast;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ctrl_start = 1'b0;
    logic         ctrl_done;
    logic [63:0]  nfa_addr = '0;
    logic [31:0]  nfa_numcls = '0;
    logic [63:0]  query_addr = '0;
    logic [31:0]  query_numcls = '0;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b1;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;
    logic [511:0] m_axi_rdata = '0;
    logic         m_axi_rlast = 1'b0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic         m_axis_ttype;
    logic         m_axis_tlast;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    ar_t   mem_q[$];
    int    ar_cyc[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   ar_acc_cnt = 0;
    int   cyc = 0;
    int   model_out = 0;
    int   last_nfa_beat_cyc = 0;
    int   r_credit = BIG;
    logic stall_mode = 1'b0;
    logic mflush = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mct_rd_scheduler #(
        .C_ADDR_WIDTH      (64),
        .C_DATA_WIDTH      (512),
        .C_BURST_LEN       (16),
        .C_MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_start    (ctrl_start),
        .ctrl_done     (ctrl_done),
        .nfa_addr      (nfa_addr),
        .nfa_numcls    (nfa_numcls),
        .query_addr    (query_addr),
        .query_numcls  (query_numcls),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_ttype  (m_axis_ttype),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Monitor: pops scoreboard entries whenever the DUT presents a handshake.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    ar_t         e_ar;
    beat_t       e_bt;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            model_out  = 0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!m_axi_arvalid || m_axi_araddr !== prev_addr || m_axi_arlen !== prev_len) begin
                    n_err++;
                    $display("FAIL ar_hold: got v=%0b addr=%h len=%0d, want v=1 addr=%h len=%0d",
                             m_axi_arvalid, m_axi_araddr, m_axi_arlen, prev_addr, prev_len);
                end
            end
            prev_stall = m_axi_arvalid && !m_axi_arready;
            prev_addr  = m_axi_araddr;
            prev_len   = m_axi_arlen;

            if (m_axi_arvalid && m_axi_arready) begin
                ar_acc_cnt++;
                ar_cyc.push_back(cyc);
                model_out++;
                n_vec++;
                if (exp_ar.size() == 0) begin
                    n_err++;
                    $display("FAIL ar_unexpected: got addr=%h len=%0d, want no AR", m_axi_araddr, m_axi_arlen);
                end else begin
                    e_ar = exp_ar.pop_front();
                    if (m_axi_araddr !== e_ar.addr || m_axi_arlen !== e_ar.len) begin
                        n_err++;
                        $display("FAIL ar: got addr=%h len=%0d, want addr=%h len=%0d",
                                 m_axi_araddr, m_axi_arlen, e_ar.addr, e_ar.len);
                    end
                end
                n_vec++;
                if (model_out > MAXO) begin
                    n_err++;
                    $display("FAIL outstanding: got %0d, want <= %0d", model_out, MAXO);
                end
            end

            if (m_axis_tvalid && m_axis_tready) begin
                n_vec++;
                if (exp_beat.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got data=%h, want no beat", m_axis_tdata[63:0]);
                end else begin
                    e_bt = exp_beat.pop_front();
                    if (m_axis_tdata !== e_bt.data || m_axis_ttype !== e_bt.ttype ||
                        m_axis_tlast !== e_bt.tlast || m_axi_rready !== 1'b1) begin
                        n_err++;
                        $display("FAIL beat: got data=%h type=%0b last=%0b rready=%0b, want data=%h type=%0b last=%0b rready=1",
                                 m_axis_tdata[63:0], m_axis_ttype, m_axis_tlast, m_axi_rready,
                                 e_bt.data[63:0], e_bt.ttype, e_bt.tlast);
                    end
                end
                if (m_axis_ttype == 1'b0 && m_axis_tlast) last_nfa_beat_cyc = cyc;
                if (m_axi_rlast) model_out--;
            end

            if (ctrl_done) done_cnt++;
        end
    end

    // In-order AXI read slave; data of each beat is its own byte address.
    initial begin : mem_model
        logic a_fire, r_fire, r_last_s;
        ar_t  a_s;
        int   beat_i;
        int   stall_cnt;
        beat_i    = 0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            a_fire    = m_axi_arvalid && m_axi_arready && !rst;
            a_s.addr  = m_axi_araddr;
            a_s.len   = m_axi_arlen;
            r_fire    = m_axi_rvalid && m_axi_rready;
            r_last_s  = m_axi_rlast;
            @(posedge clk);
            #1;
            if (mflush) begin
                mem_q.delete();
                beat_i       = 0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                mflush       = 1'b0;
            end else begin
                if (a_fire) mem_q.push_back(a_s);
                if (r_fire) begin
                    if (r_last_s) begin
                        mem_q.delete(0);
                        beat_i = 0;
                        if (r_credit > 0) r_credit--;
                    end else begin
                        beat_i++;
                    end
                end
                if (!(m_axi_rvalid && !r_fire)) begin
                    if (mem_q.size() != 0 && r_credit > 0 && !(stall_mode && $urandom_range(0, 3) == 0)) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = 512'(mem_q[0].addr + 64'(beat_i) * 64'd64);
                        m_axi_rlast  = (beat_i == int'(mem_q[0].len));
                    end else begin
                        m_axi_rvalid = 1'b0;
                        m_axi_rlast  = 1'b0;
                    end
                end
            end
            if (stall_mode) begin
                if (a_fire) stall_cnt = $urandom_range(0, 5);
                m_axi_arready = (stall_cnt == 0);
                if (stall_cnt > 0) stall_cnt--;
            end else begin
                stall_cnt     = 0;
                m_axi_arready = 1'b1;
            end
            m_axis_tready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_stream(input logic [63:0] base, input int n, input logic ttype);
        beat_t       bt;
        ar_t         ar;
        logic [63:0] a;
        int          rem;
        int          b;
        for (int i = 0; i < n; i++) begin
            bt.data  = 512'(base + 64'(i) * 64'd64);
            bt.ttype = ttype;
            bt.tlast = (i == n - 1);
            exp_beat.push_back(bt);
        end
        a   = base;
        rem = n;
        while (rem > 0) begin
            b       = (rem < 16) ? rem : 16;
            ar.addr = a;
            ar.len  = 8'(b - 1);
            exp_ar.push_back(ar);
            a   = a + 64'(b) * 64'd64;
            rem = rem - b;
        end
    endtask

    task automatic start_run(input logic [63:0] nb, input int nn, input logic [63:0] qb, input int qn);
        push_stream(nb, nn, 1'b0);
        push_stream(qb, qn, 1'b1);
        nfa_addr     = nb;
        nfa_numcls   = 32'(nn);
        query_addr   = qb;
        query_numcls = 32'(qn);
        ctrl_start   = 1'b1;
        tick(1);
        ctrl_start   = 1'b0;
        // Scramble inputs: the run must use the values latched at start.
        nfa_addr     = 64'hDEAD_0000;
        nfa_numcls   = 32'd7;
        query_addr   = 64'hBEEF_0000;
        query_numcls = 32'd9;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
        check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
        check({name, "_beat_left"}, 64'(exp_beat.size()), 64'd0);
    endtask

    initial begin : stim
        int d0;
        int a0;
        int k;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_tvalid_done", 64'({m_axis_tvalid, ctrl_done}), 64'd0);

        // 40 NFA + 20 query lines, arready always high
        d0 = done_cnt;
        start_run(64'h1000_0000, 40, 64'h2000_0000, 20);
        wait_done("basic", d0, 2000);

        // NFA phase skipped
        d0 = done_cnt;
        start_run(64'h8000_0000, 0, 64'h8100_0000, 5);
        wait_done("nfa0", d0, 500);

        // Both phases empty: done one cycle after start, no AR
        d0 = done_cnt;
        start_run(64'h9000_0000, 0, 64'h9100_0000, 0);
        check("empty_done_pulse", 64'(ctrl_done), 64'd1);
        tick(1);
        check("empty_done_low", 64'(ctrl_done), 64'd0);
        wait_done("empty", d0, 10);

        // Outstanding limit with R channel withheld
        r_credit = 0;
        d0 = done_cnt;
        a0 = ar_acc_cnt;
        start_run(64'hA000_0000, 64, 64'hA100_0000, 0);
        tick(30);
        check("out_limit_ars", 64'(ar_acc_cnt - a0), 64'd2);
        check("out_limit_arvalid", 64'(m_axi_arvalid), 64'd0);
        r_credit = 1;
        tick(40);
        check("out_one_more_ar", 64'(ar_acc_cnt - a0), 64'd3);
        r_credit = BIG;
        wait_done("outstanding", d0, 1000);

        // Phase transition timing
        r_credit = 0;
        d0 = done_cnt;
        a0 = ar_acc_cnt;
        start_run(64'h5000_0000, 16, 64'h6000_0000, 16);
        tick(20);
`ifdef MCT_RD_PHASE_BARRIER_EN
        check("barrier_hold_ars", 64'(ar_acc_cnt - a0), 64'd1);
`else
        check("b2b_ars", 64'(ar_acc_cnt - a0), 64'd2);
        if (ar_cyc.size() > a0 + 1)
            check("qry_ar_next_cycle", 64'(ar_cyc[a0 + 1] - ar_cyc[a0]), 64'd1);
`endif
        r_credit = BIG;
        wait_done("phase", d0, 1000);
`ifdef MCT_RD_PHASE_BARRIER_EN
        if (ar_cyc.size() > a0 + 1)
            check("qry_ar_after_nfa_last", 64'(ar_cyc[a0 + 1] > last_nfa_beat_cyc), 64'd1);
`endif

        // Random arready / tready / rvalid stalls
        stall_mode = 1'b1;
        d0 = done_cnt;
        start_run(64'h3000_0000, 40, 64'h4000_5000, 20);
        wait_done("stall", d0, 4000);
        stall_mode = 1'b0;
        tick(3);

        // Reset while in QRY_AR
        r_credit = 1;
        d0 = done_cnt;
        a0 = ar_acc_cnt;
        start_run(64'hB000_0000, 16, 64'hC000_0000, 64);
        k = 0;
        while ((ar_acc_cnt - a0 < 3 || exp_beat.size() != 64) && k < 300) begin
            tick(1);
            k++;
        end
        check("abort_ars_before_rst", 64'(ar_acc_cnt - a0), 64'd3);
        tick(5);
        rst    = 1'b1;
        mflush = 1'b1;
        tick(1);
        check("abort_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("abort_rready", 64'(m_axi_rready), 64'd0);
        check("abort_done", 64'(ctrl_done), 64'd0);
        rst = 1'b0;
        exp_ar.delete();
        exp_beat.delete();
        r_credit = BIG;
        tick(5);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        d0 = done_cnt;
        start_run(64'h7000_0000, 3, 64'h7100_0000, 2);
        wait_done("restart", d0, 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
